// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch stage. Owns the fetch PC and issues one word request
//   per cycle to a 1-cycle-latency instruction memory. Returned words are
//   buffered with their PCs in a DEPTH-entry FIFO and handed to decode in
//   order. Decode back-pressure arrives as out_ready; a taken branch arrives
//   as redirect_valid/redirect_pc and discards everything queued or in flight.
//
//   Ports
//     clk, reset           clock, synchronous active-low reset
//     imem_req/imem_addr   request valid and word address (= fetch PC)
//     imem_rdata/rvalid    returned word, valid one cycle after imem_req
//     out_valid/pc/instr   head entry of the queue
//     out_ready            decode accepts head this cycle
//     redirect_valid/pc    taken branch: flush and refetch from redirect_pc
//     perf_fetched         words delivered to decode (saturating)
//     perf_flushed         entries discarded by redirects (saturating)
//
//   Build option: define FETCH_QUEUE_PERF_EN to instantiate the performance
//   counters; otherwise both perf outputs are tied to zero.
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                PC_W     = 64,
   parameter logic [PC_W-1:0]   RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_rvalid,
   output logic             out_valid,
   output logic [PC_W-1:0]  out_pc,
   output logic [31:0]      out_instr,
   input  logic             out_ready,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_flushed
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  fetch_pc_q,   fetch_pc_d;
   logic [PC_W-1:0]  pending_pc_q, pending_pc_d;
   logic [CNT_W-1:0] count_q,      count_d;
   logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
   logic             inflight_q,   inflight_d;
   logic [PC_W-1:0]  pc_mem_q    [DEPTH];
   logic [PC_W-1:0]  pc_mem_d    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];
   logic [31:0]      instr_mem_d [DEPTH];

   logic             push;
   logic             pop;
   logic [CNT_W:0]   occupancy;

   // Slots already spoken for: queued entries plus the word still in flight.
   // Built from flops only, so out_ready never reaches imem_req.
   assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign imem_req  = reset & ~redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
   assign imem_addr = fetch_pc_q;

   assign out_valid = (count_q != '0);
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];

   // A return with nothing in flight is stray data (e.g. from a request made
   // just before reset) and is never written.
   assign push = imem_rvalid & inflight_q & ~redirect_valid;
   assign pop  = out_valid & out_ready;

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      inflight_d   = imem_req;
      pc_mem_d     = pc_mem_q;
      instr_mem_d  = instr_mem_q;

      if (imem_req) begin
         fetch_pc_d   = fetch_pc_q + PC_W'(4);
         pending_pc_d = fetch_pc_q;
      end

      if (redirect_valid) begin
         // Queue contents and any returning word belong to the wrong path.
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]    = pending_pc_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= RESET_PC;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         inflight_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         inflight_q   <= inflight_d;
         pc_mem_q     <= pc_mem_d;
         instr_mem_q  <= instr_mem_d;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;
   logic [32:0] flush_sum;

   // Everything discarded by a redirect: queued entries plus the in-flight
   // word, minus the head if decode took it in the same cycle.
   assign flush_sum = {1'b0, perf_flushed_q} + 33'(count_q) + 33'(inflight_q)
                    - 33'(pop);

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_flushed_d = perf_flushed_q;
      if (pop && perf_fetched_q != '1)
         perf_fetched_d = perf_fetched_q + 32'd1;
      if (redirect_valid)
         perf_flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`else
   assign perf_fetched = '0;
   assign perf_flushed = '0;
`endif

   // Memory must only answer requests this block actually made.
   a_rvalid_has_req: assert property (@(posedge clk) disable iff (!reset)
      imem_rvalid |-> inflight_q);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          PC_W     = 64;
   localparam logic [63:0] RESET_PC = 64'd0;

   logic            clk = 1'b0;
   logic            reset;
   logic            imem_req;
   logic [63:0]     imem_addr;
   logic [31:0]     imem_rdata = 32'd0;
   logic            imem_rvalid = 1'b0;
   logic            out_valid;
   logic [63:0]     out_pc;
   logic [31:0]     out_instr;
   logic            out_ready;
   logic            redirect_valid;
   logic [63:0]     redirect_pc;
   logic [31:0]     perf_fetched;
   logic [31:0]     perf_flushed;

   fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_ready      (out_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed)
   );

   always #5 clk = ~clk;

   // Memory image: an address-derived word, so every PC has a distinct value.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
   endfunction

   // 1-cycle-latency instruction memory.
   always @(posedge clk) begin
      imem_rvalid <= imem_req;
      imem_rdata  <= mem_word(imem_addr);
   end

   int n_cmp = 0;
   int n_err = 0;
   int n_pops = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: decode sees a sequential stream of words starting at
   // the most recent reset or redirect target; the queue holds the upcoming
   // part of that stream.
   logic [63:0] exp_q[$];
   logic [63:0] next_pc;

   task automatic topup();
      while (exp_q.size() < 8) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 64'd4;
      end
   endtask

   task automatic reload(input logic [63:0] pc);
      exp_q.delete();
      next_pc = pc;
      topup();
   endtask

   task automatic monitor();
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            reload(RESET_PC);
         end else begin
            if (out_valid && out_ready) begin
               e = exp_q.pop_front();
               chk("sb_pc", out_pc, e);
               chk("sb_instr", 64'(out_instr), 64'(mem_word(e)));
               n_pops++;
            end
            if (redirect_valid) reload(redirect_pc);
            topup();
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the caller in the first cycle with reset released.
   task automatic do_reset(input logic rdy);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = rdy;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      int nreq;
      int pops0;
      reset          = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      fork
         monitor();
      join_none

      // --- reset state, then streaming with out_ready=1 ---
      step();
      step();
      @(negedge clk);
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_pc", out_pc, 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_perf", 64'(perf_fetched) + 64'(perf_flushed), 64'd0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("t1_req0", 64'(imem_req), 64'd1);
      chk("t1_addr0", imem_addr, 64'd0);
      chk("t1_valid0", 64'(out_valid), 64'd0);
      step();
      @(negedge clk);
      chk("t1_addr1", imem_addr, 64'd4);
      chk("t1_valid1", 64'(out_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge clk);
         chk("t1_valid", 64'(out_valid), 64'd1);
         chk("t1_pc", out_pc, 64'(4 * k));
      end

      // --- out_ready=0 from reset: fill, then drain with no gaps ---
      do_reset(1'b0);
      nreq = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (imem_req) begin
            chk("t2_addr", imem_addr, 64'(4 * nreq));
            nreq++;
         end
         step();
      end
      chk("t2_nreq", 64'(nreq), 64'd4);
      @(negedge clk);
      chk("t2_req_off", 64'(imem_req), 64'd0);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_head", out_pc, 64'd0);
      chk("t2_next_addr", imem_addr, 64'd16);
      step();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t2_drain_valid", 64'(out_valid), 64'd1);
         chk("t2_drain_pc", out_pc, 64'(4 * k));
         step();
      end

      // --- full queue plus one pop ---
      do_reset(1'b0);
      repeat (8) step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_pop_pc", out_pc, 64'd0);
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("t3_req", 64'(imem_req), 64'd1);
      chk("t3_addr", imem_addr, 64'd16);
      chk("t3_head", out_pc, 64'd4);
      repeat (4) step();
      @(negedge clk);
      chk("t3_refull", 64'(imem_req), 64'd0);
      chk("t3_refull_addr", imem_addr, 64'd20);

      // --- redirect with 3 queued + 1 in flight ---
      do_reset(1'b0);
      repeat (4) step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      @(negedge clk);
      chk("t4_req_redir", 64'(imem_req), 64'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_valid1", 64'(out_valid), 64'd0);
      chk("t4_req1", 64'(imem_req), 64'd1);
      chk("t4_addr1", imem_addr, 64'h100);
`ifdef FETCH_QUEUE_PERF_EN
      chk("t4_flushed", 64'(perf_flushed), 64'd4);
`else
      chk("t4_flushed", 64'(perf_flushed), 64'd0);
`endif
      step();
      @(negedge clk);
      chk("t4_valid2", 64'(out_valid), 64'd0);
      // Request issued the cycle after the redirect; 2-cycle fill latency.
      step();
      @(negedge clk);
      chk("t4_valid3", 64'(out_valid), 64'd1);
      chk("t4_pc3", out_pc, 64'h100);

      // --- redirect during a return, then a second redirect ---
      do_reset(1'b1);
      repeat (6) step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      step();
      redirect_pc = 64'h200;
      @(negedge clk);
      chk("t5_req_r2", 64'(imem_req), 64'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t5_req", 64'(imem_req), 64'd1);
      chk("t5_addr", imem_addr, 64'h200);
      step();
      @(negedge clk);
      chk("t5_valid_gap", 64'(out_valid), 64'd0);
      step();
      @(negedge clk);
      chk("t5_valid", 64'(out_valid), 64'd1);
      chk("t5_pc", out_pc, 64'h200);
      step();
      @(negedge clk);
      chk("t5_pc2", out_pc, 64'h204);

      // --- reset while count=3 and redirect asserted ---
      do_reset(1'b0);
      repeat (4) step();
      reset          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h300;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_addr", imem_addr, RESET_PC);
      chk("t6_req", 64'(imem_req), 64'd0);
      chk("t6_perf", 64'(perf_fetched) + 64'(perf_flushed), 64'd0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_restart_req", 64'(imem_req), 64'd1);
      chk("t6_restart_addr", imem_addr, RESET_PC);
      step();
      step();
      @(negedge clk);
      chk("t6_restart_valid", 64'(out_valid), 64'd1);
      chk("t6_restart_pc", out_pc, RESET_PC);

      // --- randomized traffic against the stream model ---
      pops0 = n_pops;
      for (int k = 0; k < 3000; k++) begin
         step();
         out_ready      = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 99) < 4);
         redirect_pc    = 64'h1000 + 64'($urandom_range(0, 255)) * 64'd4;
         reset          = ($urandom_range(0, 499) != 0);
      end
      step();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      repeat (4) step();
      chk("rand_progress", 64'(n_pops - pops0 > 500), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
